// File: rtl/i2c_slave_receiver.sv
// Write-only I2C slave receiver: oversampled SCL/SDA, 7-bit address match, FWFT receive FIFO.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept the general-call address 7'h00 (write).
module i2c_slave_receiver #(
   parameter int         DataWidth    = 8,
   parameter int         FifoDepth    = 16,
   parameter logic [6:0] SlaveAddress = 7'h50
) (
   input  logic                         i_CLK,
   input  logic                         i_RESET,
   input  logic                         i_ENABLE,
   input  logic                         i_SCL,
   input  logic                         i_SDA,
   output logic                         o_SDA_LOW,
   output logic [DataWidth-1:0]         o_ReadData,
   output logic                         o_ReadValid,
   input  logic                         i_ReadAck,
   output logic [$clog2(FifoDepth):0]   o_FifoCount,
   output logic                         o_Full,
   output logic                         o_Overflow,
   input  logic                         i_ClearStatus,
   output logic                         o_Busy,
   output logic                         o_StopPulse
);

   localparam int AW = $clog2(FifoDepth);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_DATA,
      S_DATA_ACK,
      S_IGNORE
   } state_t;

   state_t                 state_q;
   logic                   scl_s1_q, scl_s2_q, scl_h_q;
   logic                   sda_s1_q, sda_s2_q, sda_h_q;
   logic [2:0]             bitcnt_q;
   logic [DataWidth-2:0]   shift_q;
   logic                   ack_on_q;
   logic                   sda_low_q;
   logic                   stop_pulse_q;

   logic [DataWidth-1:0]   mem_q [FifoDepth];
   logic [AW-1:0]          wr_q, rd_q;
   logic [CW-1:0]          count_q;
   logic                   ovf_q;

   logic                   scl_rise, scl_fall, start_ev, stop_ev;
   logic [DataWidth-1:0]   byte_d;
   logic                   last_bit, addr_hit, pop, can_accept, data_done, push, ovf_set;

   always_comb begin
      scl_rise   = scl_s2_q & ~scl_h_q;
      scl_fall   = ~scl_s2_q & scl_h_q;
      start_ev   = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
      stop_ev    = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
      byte_d     = {shift_q, sda_s2_q};
      last_bit   = scl_rise && (bitcnt_q == 3'd7);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
      addr_hit   = ~byte_d[0] && ((byte_d[DataWidth-1:1] == SlaveAddress) ||
                                  (byte_d[DataWidth-1:1] == '0));
`else
      addr_hit   = ~byte_d[0] && (byte_d[DataWidth-1:1] == SlaveAddress);
`endif
      pop        = (count_q != '0) && i_ReadAck;
      can_accept = (count_q != CW'(FifoDepth)) || pop;
      data_done  = i_ENABLE && !start_ev && !stop_ev && (state_q == S_DATA) && last_bit;
      push       = data_done && can_accept;
      ovf_set    = data_done && !can_accept;
   end

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         {scl_s1_q, scl_s2_q, scl_h_q} <= '1;
         {sda_s1_q, sda_s2_q, sda_h_q} <= '1;
         state_q      <= S_IDLE;
         bitcnt_q     <= '0;
         shift_q      <= '0;
         ack_on_q     <= 1'b0;
         sda_low_q    <= 1'b0;
         stop_pulse_q <= 1'b0;
      end else begin
         scl_s1_q     <= i_SCL;
         scl_s2_q     <= scl_s1_q;
         scl_h_q      <= scl_s2_q;
         sda_s1_q     <= i_SDA;
         sda_s2_q     <= sda_s1_q;
         sda_h_q      <= sda_s2_q;
         stop_pulse_q <= 1'b0;
         if (!i_ENABLE) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            ack_on_q  <= 1'b0;
            sda_low_q <= 1'b0;
         end else if (start_ev) begin
            state_q   <= S_ADDR;
            bitcnt_q  <= '0;
            ack_on_q  <= 1'b0;
            sda_low_q <= 1'b0;
         end else if (stop_ev) begin
            stop_pulse_q <= state_q inside {S_ADDR_ACK, S_DATA, S_DATA_ACK};
            state_q      <= S_IDLE;
            bitcnt_q     <= '0;
            ack_on_q     <= 1'b0;
            sda_low_q    <= 1'b0;
         end else begin
            case (state_q)
               S_ADDR, S_DATA: begin
                  if (scl_rise) begin
                     shift_q  <= byte_d[DataWidth-2:0];
                     bitcnt_q <= bitcnt_q + 3'd1;
                     if (last_bit) begin
                        if (state_q == S_ADDR) state_q <= addr_hit ? S_ADDR_ACK : S_IGNORE;
                        else                   state_q <= can_accept ? S_DATA_ACK : S_IGNORE;
                     end
                  end
               end
               // first SCL fall opens the ACK window, second one closes it
               S_ADDR_ACK, S_DATA_ACK: begin
                  if (scl_fall) begin
                     if (!ack_on_q) begin
                        ack_on_q  <= 1'b1;
                        sda_low_q <= 1'b1;
                     end else begin
                        ack_on_q  <= 1'b0;
                        sda_low_q <= 1'b0;
                        bitcnt_q  <= '0;
                        state_q   <= S_DATA;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge i_CLK) begin
      if (push) mem_q[wr_q] <= byte_d;
   end

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
         if (ovf_set)            ovf_q <= 1'b1;
         else if (i_ClearStatus) ovf_q <= 1'b0;
      end
   end

   assign o_SDA_LOW   = sda_low_q;
   assign o_ReadValid = (count_q != '0);
   assign o_ReadData  = (count_q != '0) ? mem_q[rd_q] : '0;
   assign o_FifoCount = count_q;
   assign o_Full      = (count_q == CW'(FifoDepth));
   assign o_Overflow  = ovf_q;
   assign o_Busy      = (state_q != S_IDLE);
   assign o_StopPulse = stop_pulse_q;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Directed bench for i2c_slave_receiver: bit-banged I2C master with open-drain SDA model.
module tb_i2c_slave_receiver;

   logic       clk = 1'b0;
   logic       rst, en, m_scl, m_sda, rd_ack, clr;
   logic       sda_low, rvalid, full, ovf, busy, stop_p;
   logic [7:0] rdata;
   logic [4:0] fcount;
   logic       bus_sda;

   int n_cmp = 0, n_err = 0, ack_windows = 0, stop_pulses = 0;
   logic sda_low_prev = 1'b0;

   assign bus_sda = m_sda & ~sda_low;

   i2c_slave_receiver #(.DataWidth(8), .FifoDepth(16), .SlaveAddress(7'h50)) dut (
      .i_CLK(clk), .i_RESET(rst), .i_ENABLE(en), .i_SCL(m_scl), .i_SDA(bus_sda),
      .o_SDA_LOW(sda_low), .o_ReadData(rdata), .o_ReadValid(rvalid), .i_ReadAck(rd_ack),
      .o_FifoCount(fcount), .o_Full(full), .o_Overflow(ovf), .i_ClearStatus(clr),
      .o_Busy(busy), .o_StopPulse(stop_p)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sda_low && !sda_low_prev) ack_windows++;
      sda_low_prev = sda_low;
      if (stop_p) stop_pulses++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;
      wait_clk(8);
      m_scl = 1'b1;
      wait_clk(8);
      m_scl = 1'b0;
      wait_clk(1);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic nack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      m_sda = 1'b1;
      wait_clk(8);
      m_scl = 1'b1;
      wait_clk(4);
      nack = bus_sda;
      wait_clk(4);
      m_scl = 1'b0;
      wait_clk(1);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      wait_clk(8);
      m_scl = 1'b1;
      wait_clk(8);
      m_sda = 1'b0;
      wait_clk(8);
      m_scl = 1'b0;
      wait_clk(1);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      wait_clk(8);
      m_scl = 1'b1;
      wait_clk(8);
      m_sda = 1'b1;
      wait_clk(8);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      check_eq(tag, 32'(rdata), 32'(exp));
      rd_ack = 1'b1;
      wait_clk(1);
      rd_ack = 1'b0;
   endtask

   initial begin
      logic       nack;
      logic [7:0] v;
      int         base_ack, base_sp;

      rst = 1'b1; en = 1'b0; m_scl = 1'b1; m_sda = 1'b1; rd_ack = 1'b0; clr = 1'b0;
      wait_clk(2);
      check_eq("rst_sda_low", 32'(sda_low), 32'd0);
      check_eq("rst_valid",   32'(rvalid),  32'd0);
      check_eq("rst_count",   32'(fcount),  32'd0);
      check_eq("rst_full",    32'(full),    32'd0);
      check_eq("rst_ovf",     32'(ovf),     32'd0);
      check_eq("rst_busy",    32'(busy),    32'd0);
      check_eq("rst_stop",    32'(stop_p),  32'd0);
      check_eq("rst_rdata",   32'(rdata),   32'd0);
      rst = 1'b0; en = 1'b1;
      wait_clk(4);

      // own address, two data bytes
      base_ack = ack_windows; base_sp = stop_pulses;
      i2c_start();
      send_byte(8'hA0, nack); check_eq("t2_addr_ack", 32'(nack), 32'd0);
      send_byte(8'h3C, nack); check_eq("t2_d0_ack",   32'(nack), 32'd0);
      send_byte(8'h7E, nack); check_eq("t2_d1_ack",   32'(nack), 32'd0);
      i2c_stop();
      wait_clk(4);
      check_eq("t2_ack_windows", 32'(ack_windows - base_ack), 32'd3);
      check_eq("t2_stop_pulses", 32'(stop_pulses - base_sp),  32'd1);
      check_eq("t2_count",       32'(fcount),                 32'd2);
      pop_check("t2_pop0", 8'h3C);
      pop_check("t2_pop1", 8'h7E);
      check_eq("t2_empty", 32'(rvalid), 32'd0);

      // wrong address
      base_sp = stop_pulses;
      i2c_start();
      send_byte(8'hA2, nack); check_eq("t3_addr_nack", 32'(nack), 32'd1);
      check_eq("t3_busy_ignore", 32'(busy), 32'd1);
      send_byte(8'h11, nack); check_eq("t3_data_nack", 32'(nack), 32'd1);
      check_eq("t3_count", 32'(fcount), 32'd0);
      i2c_stop();
      wait_clk(4);
      check_eq("t3_busy_idle", 32'(busy), 32'd0);
      check_eq("t3_no_stop_pulse", 32'(stop_pulses - base_sp), 32'd0);

      // overflow on the 17th byte
      i2c_start();
      send_byte(8'hA0, nack); check_eq("t4_addr_ack", 32'(nack), 32'd0);
      for (int i = 0; i < 17; i++) begin
         v = 8'(16 + i);
         send_byte(v, nack);
         check_eq($sformatf("t4_byte%0d_ack", i + 1), 32'(nack), (i == 16) ? 32'd1 : 32'd0);
      end
      check_eq("t4_full",  32'(full),   32'd1);
      check_eq("t4_ovf",   32'(ovf),    32'd1);
      check_eq("t4_count", 32'(fcount), 32'd16);
      base_sp = stop_pulses;
      i2c_stop();
      wait_clk(4);
      check_eq("t4_no_stop_pulse", 32'(stop_pulses - base_sp), 32'd0);
      clr = 1'b1;
      wait_clk(1);
      clr = 1'b0;
      check_eq("t4_ovf_clear",  32'(ovf),    32'd0);
      check_eq("t4_count_kept", 32'(fcount), 32'd16);
      for (int i = 0; i < 16; i++) begin
         v = 8'(16 + i);
         pop_check($sformatf("t4_pop%0d", i), v);
      end
      check_eq("t4_empty", 32'(rvalid), 32'd0);

      // repeated START after 4 data bits
      base_sp = stop_pulses;
      i2c_start();
      send_byte(8'hA0, nack); check_eq("t5_addr0_ack", 32'(nack), 32'd0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      i2c_start();
      send_byte(8'hA0, nack); check_eq("t5_addr1_ack", 32'(nack), 32'd0);
      send_byte(8'h55, nack); check_eq("t5_data_ack",  32'(nack), 32'd0);
      i2c_stop();
      wait_clk(4);
      check_eq("t5_stop_pulse", 32'(stop_pulses - base_sp), 32'd1);
      check_eq("t5_count", 32'(fcount), 32'd1);
      pop_check("t5_pop", 8'h55);
      check_eq("t5_empty", 32'(rvalid), 32'd0);

      // general call
      i2c_start();
      send_byte(8'h00, nack);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
      check_eq("t6_gc_ack", 32'(nack), 32'd0);
      send_byte(8'h99, nack); check_eq("t6_gc_data_ack", 32'(nack), 32'd0);
      i2c_stop();
      wait_clk(4);
      check_eq("t6_count", 32'(fcount), 32'd1);
      pop_check("t6_pop", 8'h99);
`else
      check_eq("t6_gc_nack", 32'(nack), 32'd1);
      send_byte(8'h99, nack); check_eq("t6_gc_data_nack", 32'(nack), 32'd1);
      i2c_stop();
      wait_clk(4);
      check_eq("t6_count", 32'(fcount), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
